// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and default line settings shared by the UART blocks.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_t;
   localparam int UART_DEFAULT_BAUD      = 115_200;
   localparam int UART_DEFAULT_DATA_BITS = 8;
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: two-flop synchroniser for an asynchronous single-bit input.
module bit_synchronizer #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync
);
   logic [1:0] r_meta;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_meta <= {2{RESET_VAL}};
      else       r_meta <= {r_meta[0], i_async};
   assign o_sync = r_meta[1];
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: mid-bit sampling UART receiver feeding a valid/ready holding register.
module uart_rx_deserializer
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int BAUD_RATE   = UART_DEFAULT_BAUD,
   parameter int DATA_BITS   = UART_DEFAULT_DATA_BITS
) (
   input  logic                 CLK100MHZ,
   input  logic                 ck_rst,
   input  logic                 uart_rxd_out,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 rx_busy
);
   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam int BW           = $clog2(DATA_BITS);
   uart_rx_state_t       r_state, w_next;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bit_idx;
   logic [DATA_BITS-1:0] r_shift, r_data;
   logic                 r_valid, r_frame_err, r_overrun;
   logic                 w_rxd, w_bit_end, w_half, w_last_bit;
   logic                 w_stop_ok, w_stop_bad, w_load, w_pop;
   bit_synchronizer #(.RESET_VAL(1'b1)) u_rxd_sync (
      .i_clk   (CLK100MHZ),
      .i_rst   (ck_rst),
      .i_async (uart_rxd_out),
      .o_sync  (w_rxd)
   );
   assign w_bit_end  = r_cnt == CW'(CLKS_PER_BIT - 1);
   assign w_half     = r_cnt == CW'(HALF_BIT - 1);
   assign w_last_bit = r_bit_idx == BW'(DATA_BITS - 1);
   assign w_stop_ok  = r_state == STOP && w_bit_end && w_rxd;
   assign w_stop_bad = r_state == STOP && w_bit_end && !w_rxd;
   assign w_pop      = r_valid && rx_ready;
   // A full register still accepts the new byte when the old one leaves in the same cycle.
   assign w_load     = w_stop_ok && (!r_valid || rx_ready);
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:      if (!w_rxd) w_next = START;
         START:     if (w_half) w_next = w_rxd ? IDLE : DATA;
         DATA:      if (w_bit_end && w_last_bit) w_next = STOP;
         STOP:      if (w_bit_end) w_next = w_rxd ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (w_rxd) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end
   always_ff @(posedge CLK100MHZ or posedge ck_rst)
      if (ck_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= (w_next != r_state || w_bit_end || r_state inside {IDLE, WAIT_IDLE}) ? '0 : r_cnt + CW'(1);
         r_bit_idx   <= (r_state != DATA) ? '0 : w_bit_end ? r_bit_idx + BW'(1) : r_bit_idx;
         if (r_state == DATA && w_bit_end) r_shift <= {w_rxd, r_shift[DATA_BITS-1:1]};
         if (w_load) r_data <= r_shift;
         r_valid     <= w_load || (r_valid && !w_pop);
         r_frame_err <= w_stop_bad;
         r_overrun   <= w_stop_ok && r_valid && !rx_ready;
      end
   assign rx_data     = r_data;
   assign rx_valid    = r_valid;
   assign frame_err   = r_frame_err;
   assign overrun_err = r_overrun;
   assign rx_busy     = r_state != IDLE;
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
Receive half of the board-level UART path. It takes the Arty host-to-FPGA serial line (uart_rxd_out), synchronises it, and detects and validates start bits. It then samples data bits mid-bit, checks the stop bit, and presents each received byte on a valid/ready output register. It sits behind the board wrapper and feeds the UART controller's command/data logic.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency.
BAUD_RATE, 115_200, line rate.
DATA_BITS, 8, data bits per frame (5..9), LSB first, no parity, 1 stop bit.
CLKS_PER_BIT, localparam = CLK_FREQ_HZ/BAUD_RATE (integer division; 868 at defaults). Must be >= 4.
HALF_BIT, localparam = CLKS_PER_BIT/2 (434 at defaults).

Ports:
CLK100MHZ  in  1  system clock, all logic on rising edge.
ck_rst  in  1  asynchronous, active-high reset.
uart_rxd_out  in  1  serial line from host, idle high, asynchronous to CLK100MHZ.
rx_data  out  DATA_BITS  received byte, stable while rx_valid=1.
rx_valid  out  1  rx_data holds an unconsumed byte.
rx_ready  in  1  consumer accepts; transfer on rx_valid && rx_ready.
frame_err  out  1  one-cycle pulse: stop bit sampled low.
overrun_err  out  1  one-cycle pulse: byte completed while the holding register was full and not being drained.
rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert by the clock domain):
  - state=IDLE; rx_data=0; rx_valid=0; frame_err=0; overrun_err=0; rx_busy=0.
  - Synchroniser flops reset to 1 (idle line).
  - Bit counter and clock counter reset to 0.
  - Reset mid-frame discards the partial frame. No error pulse is produced.
- Synchroniser: 2 flops; rxd_s is the second flop output. Latency is 2 cycles.
- Clock counter cnt: counts 0..CLKS_PER_BIT-1 and clears on every state transition.
- IDLE: when rxd_s==0, go to START with cnt=0.
- START: when cnt==HALF_BIT-1, sample rxd_s.
  - If 0: go to DATA with cnt=0 and bit_idx=0.
  - If 1: glitch; go to IDLE with no pulse.
- DATA: when cnt==CLKS_PER_BIT-1, shift rxd_s into the MSB of the shift register (right shift, so the first bit lands at bit 0) and increment bit_idx.
  - After the DATA_BITS-th sample, go to STOP.
- STOP: when cnt==CLKS_PER_BIT-1, sample rxd_s.
  - If 1: good frame; go to IDLE.
  - If 0: frame_err pulses next cycle; no byte is delivered; go to WAIT_IDLE.
- WAIT_IDLE: stay while rxd_s==0 (break or stuck-low line); go to IDLE when rxd_s==1. Prevents false starts during a break.
- Good-frame delivery, evaluated in the cycle of the stop sample:
  - rx_valid==0: load rx_data and set rx_valid=1 on the next edge.
  - rx_valid==1 and rx_ready==1 (simultaneous pop): old byte transfers, new byte loads, rx_valid stays 1, no overrun.
  - rx_valid==1 and rx_ready==0: new byte dropped, rx_data unchanged, overrun_err pulses one cycle.
- rx_valid clears on the edge after rx_valid && rx_ready when no new byte lands that cycle.
- Latency at defaults: from the pin falling edge to rx_valid=1 is 2 + HALF_BIT + DATA_BITS*CLKS_PER_BIT + CLKS_PER_BIT + 1 cycles (~9.5 bit times).
- Baud error tolerance is set by the mid-bit sampling; there is no resync within a frame.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - Default constants UART_DEFAULT_BAUD=115200 and UART_DEFAULT_DATA_BITS=8, shared with the future transmitter.
- Sub-module: bit_synchronizer (2-flop, reset value parameterised). Reused for other asynchronous board inputs.

Test Plan:
All tests use CLK_FREQ_HZ=1_600_000 and BAUD_RATE=100_000, so CLKS_PER_BIT=16 and HALF_BIT=8.
- Good frame 0xA5, rx_ready=1 constantly -> rx_valid pulses one cycle with rx_data=0xA5; frame_err=0 and overrun_err=0 throughout; rx_valid rises at 2+8+128+16+1=155 cycles after the start edge.
- Start glitch: line low for 4 cycles, then high -> no rx_valid, no error pulse, rx_busy returns to 0 within 12 cycles.
- Frame 0x3C with stop bit driven low, then line held low for 40 cycles -> frame_err pulses once; no rx_valid; state stays WAIT_IDLE until the line goes high; a following good frame 0x81 is received correctly.
- Frames 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11 and rx_valid=1 persist; overrun_err pulses once at the end of frame 2. Then rx_ready=1 -> 0x11 transfers and rx_valid drops.
- rx_ready pulsed in exactly the stop-sample cycle of frame 0x22 while holding 0x11 -> 0x11 transferred, rx_data=0x22, rx_valid stays 1, no overrun_err.
- ck_rst asserted mid-DATA of frame 0xFF -> all outputs 0 immediately (async); after deassertion a fresh frame 0x5A is received correctly.
